usb_fifo_bridge: RTL
====================

# usb_fifo_bridge

Parametrised FT232H synchronous-245 FIFO bridge. It moves bytes between the FT232H parallel bus and two local FPGA FIFOs: RX (host to FPGA) and TX (FPGA to host). Compared with the earlier single-mode bridge it adds:
- local RX full flow control;
- round-robin arbitration with a bounded burst length;
- a guaranteed bus turnaround cycle;
- wrapping byte counters;
- an optional send-immediate flush.

It sits between the USB pads and the RX/TX FIFOs in the usb_clk_60m domain.

## Interface
Parameters:
- DATA_W, 8: bus and FIFO data width.
- BURST_MAX, 64: maximum transfers per grant; 0 means unlimited.
- CNT_W, 32: width of the byte counters.
- SIWU_IDLE, 16: idle cycles before the send-immediate pulse (macro builds only).

Ports. Clock and reset: usb_clk_60m, rst_n asynchronous active-low.
- usb_clk_60m  in  1  60 MHz clock from the FT232H
- rst_n  in  1  asynchronous reset, active-low
- usb_rxf_n  in  1  FT232H has data to read
- usb_txe_n  in  1  FT232H can accept data
- usb_oe_n  out  1  FT232H data output enable
- usb_rd_n  out  1  read strobe
- usb_wr_n  out  1  write strobe
- usb_siwu_n  out  1  send-immediate / wake-up
- usb_data_i  in  DATA_W  pad input
- usb_data_o  out  DATA_W  pad output
- usb_data_oe  out  1  pad drive enable; the tristate buffer lives at top level
- rx_wr_en  out  1  RX FIFO push
- rx_data  out  DATA_W  RX FIFO write data
- rx_full  in  1  RX FIFO full, registered flag
- tx_rd_en  out  1  TX FIFO pop; the TX FIFO is first-word-fall-through
- tx_data  in  DATA_W  TX FIFO head word
- tx_empty  in  1  TX FIFO empty, registered flag
- rx_byte_cnt  out  CNT_W  bytes received, wraps
- tx_byte_cnt  out  CNT_W  bytes sent, wraps
- busy  out  1  high whenever state is not IDLE

## Operation
States: IDLE, RD_OE, RD, WR. State is registered and one-hot.

Request terms:
- rx_req = !usb_rxf_n && !rx_full
- tx_req = !usb_txe_n && !tx_empty

Transitions:
- IDLE:
  - Only rx_req: go to RD_OE.
  - Only tx_req: go to WR.
  - Both: grant the side opposite last_grant.
  - last_grant is updated on entry to RD_OE or WR.
- RD_OE: always goes to RD after one cycle. OE is low in this cycle; no strobe.
- RD: go to IDLE on any of:
  - usb_rxf_n high;
  - rx_full high;
  - burst_cnt reaches BURST_MAX.
- WR: go to IDLE on any of:
  - usb_txe_n high;
  - tx_empty high;
  - burst_cnt reaches BURST_MAX.

Bus turnaround:
- RD never goes directly to WR; it always passes through IDLE.
- In that IDLE cycle usb_oe_n is high and usb_data_oe is low, so there is one bus-free cycle.

Output decodes (decoded from registered state, no extra flops):
- usb_oe_n = !(RD_OE || RD)
- usb_rd_n = !(RD && !rx_full && burst_ok)
- usb_wr_n = !(WR && !tx_empty && burst_ok)
- usb_data_oe = WR
- usb_data_o = tx_data

Transfer rules:
- A transfer happens on an edge where the strobe is low and the matching FT flag is low.
- rx_wr_en = !usb_rd_n && !usb_rxf_n, with rx_data = usb_data_i.
- tx_rd_en = !usb_wr_n && !usb_txe_n.
- No byte is ever pushed while rx_full is high, nor popped while tx_empty is high.

Burst counter:
- Cleared on every grant; increments once per transfer.
- Width is clog2(BURST_MAX+1).
- burst_ok = (BURST_MAX == 0) || (burst_cnt < BURST_MAX).

Byte counters increment once per transfer and wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - usb_oe_n, usb_rd_n, usb_wr_n, usb_siwu_n = 1
  - usb_data_oe, rx_wr_en, tx_rd_en, busy = 0
  - state = IDLE, last_grant = TX, so RX wins the first tie
  - all counters = 0
- Reset is asserted asynchronously: the strobes and the bus drive release immediately, including in the middle of a burst.
- Read latency: rxf_n low in IDLE gives RD_OE on the next edge, then rd_n low one edge later. The first byte is pushed at the second edge after the grant.
- Write latency: the first byte is popped on the edge after the grant.
- Sustained throughput is 1 byte per cycle.
- rx_full or usb_txe_n rising mid-burst stops transfers in the same cycle, because the strobes are combinational from the registered flags.
- A flag change at the same edge as a burst-limit hit exits once; there is no double count.

## Configuration
USB_SIWU_EN defined:
- After a WR burst ends with tx_empty high, an idle counter counts cycles while state is IDLE and tx_empty stays high.
- When the count reaches SIWU_IDLE, usb_siwu_n pulses low for exactly 1 cycle.
- Only one pulse is produced per write episode. Any new write clears the counter.

USB_SIWU_EN undefined: usb_siwu_n is tied high and no counter logic is built.

## Structure
- Package usb_bridge_pkg holds the state enum (one-hot encoding) and the grant enum (RX/TX).
- Sub-module usb_siwu_timer holds the idle counter and pulse generator, instantiated only under USB_SIWU_EN.

## Test plan
- Reset, then rxf_n low with 5 host bytes 0x11..0x15: OE goes low 1 cycle before rd_n. Exactly 5 rx_wr_en pulses with matching data. rx_byte_cnt = 5.
- TX FIFO holds 3 bytes, txe_n low: 3 wr_n-low cycles; usb_data_o = head word on each; tx_byte_cnt = 3; then back to IDLE.
- rxf_n and tx_req both held permanently, BURST_MAX=4: grants alternate RD(4), WR(4). There is exactly 1 IDLE cycle with oe_n=1 and data_oe=0 between RD and WR.
- rx_full rises after 2 bytes of a read burst: rd_n rises the same cycle, no push while full, state goes to IDLE.
- CNT_W=4, send 17 bytes: tx_byte_cnt wraps to 1. Assert rst_n low mid-write: wr_n=1 and data_oe=0 immediately.
- USB_SIWU_EN, SIWU_IDLE=16: after the last write byte, siwu_n is low exactly 1 cycle, 16 idle cycles later. No pulse if a new byte arrives at cycle 10.

Source files
------------

// File: rtl/usb_bridge_pkg.sv
// Shared types for the FT232H synchronous-245 FIFO bridge: one-hot FSM states,
// grant side, and a counter-width helper.
package usb_bridge_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StRdOe = 4'b0010,
        StRd   = 4'b0100,
        StWr   = 4'b1000
    } state_e;

    typedef enum logic {
        GrantRx = 1'b0,
        GrantTx = 1'b1
    } grant_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/usb_siwu_timer.sv
// Send-immediate timer: after a write episode, counts idle cycles with the TX FIFO
// empty and pulses siwu_n low for one cycle when the count reaches IDLE_CYCLES.
module usb_siwu_timer
    import usb_bridge_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic usb_clk_60m,
    input  logic rst_n,
    input  logic write,
    input  logic idle,
    input  logic tx_empty,
    output logic siwu_n
);

    localparam int unsigned CW = cnt_width(IDLE_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(IDLE_CYCLES);

    logic          armed_q, armed_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        armed_d = armed_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (write) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (armed_q) begin
            if (idle && tx_empty) begin
                cnt_d = cnt_q + 1'b1;
                // One pulse per episode: disarm until the next write.
                if (cnt_d == LIMIT) begin
                    pulse_d = 1'b1;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge usb_clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign siwu_n = !pulse_q;

endmodule

// File: rtl/usb_fifo_bridge.sv
// FT232H synchronous-245 bridge between the USB pads and local RX/TX FIFOs, with
// round-robin bounded bursts. Define USB_SIWU_EN to build the send-immediate timer.
module usb_fifo_bridge
    import usb_bridge_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 64,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SIWU_IDLE = 16
) (
    input  logic              usb_clk_60m,
    input  logic              rst_n,
    input  logic              usb_rxf_n,
    input  logic              usb_txe_n,
    output logic              usb_oe_n,
    output logic              usb_rd_n,
    output logic              usb_wr_n,
    output logic              usb_siwu_n,
    input  logic [DATA_W-1:0] usb_data_i,
    output logic [DATA_W-1:0] usb_data_o,
    output logic              usb_data_oe,
    output logic              rx_wr_en,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_full,
    output logic              tx_rd_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_empty,
    output logic [CNT_W-1:0]  rx_byte_cnt,
    output logic [CNT_W-1:0]  tx_byte_cnt,
    output logic              busy
);

    localparam int unsigned BURST_W = cnt_width(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    state_e             state_q, state_d;
    grant_e             last_grant_q, last_grant_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   rx_cnt_q, tx_cnt_q;
    logic               rx_req, tx_req, burst_ok, burst_end, rd_xfer, wr_xfer;

    assign rx_req   = !usb_rxf_n && !rx_full;
    assign tx_req   = !usb_txe_n && !tx_empty;
    assign burst_ok = (BURST_MAX == 0) || (burst_cnt_q < BURST_LIM);
    assign rd_xfer  = !usb_rd_n && !usb_rxf_n;
    assign wr_xfer  = !usb_wr_n && !usb_txe_n;
    // Leave on the transfer that reaches the limit, so a burst never idles in-state.
    assign burst_end = (BURST_MAX != 0) &&
                       (!burst_ok || ((rd_xfer || wr_xfer) && burst_cnt_q == BURST_LIM - 1'b1));

    always_ff @(posedge usb_clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantTx;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if ((rd_xfer || wr_xfer) && (BURST_MAX != 0)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (rx_req && (!tx_req || last_grant_q == GrantTx)) begin
                    state_d      = StRdOe;
                    last_grant_d = GrantRx;
                    burst_cnt_d  = '0;
                end else if (tx_req) begin
                    state_d      = StWr;
                    last_grant_d = GrantTx;
                    burst_cnt_d  = '0;
                end
            end
            StRdOe: state_d = StRd;
            StRd: begin
                if (usb_rxf_n || rx_full || burst_end) state_d = StIdle;
            end
            StWr: begin
                if (usb_txe_n || tx_empty || burst_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes stay combinational on the registered flags so a full/empty stops them at once.
    always_comb begin
        usb_oe_n    = 1'b1;
        usb_rd_n    = 1'b1;
        usb_wr_n    = 1'b1;
        usb_data_oe = 1'b0;
        unique case (state_q)
            StRdOe: usb_oe_n = 1'b0;
            StRd: begin
                usb_oe_n = 1'b0;
                usb_rd_n = !(!rx_full && burst_ok);
            end
            StWr: begin
                usb_wr_n    = !(!tx_empty && burst_ok);
                usb_data_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge usb_clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rd_xfer) rx_cnt_q <= rx_cnt_q + 1'b1;
            if (wr_xfer) tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    assign rx_wr_en    = rd_xfer;
    assign rx_data     = usb_data_i;
    assign tx_rd_en    = wr_xfer;
    assign usb_data_o  = tx_data;
    assign rx_byte_cnt = rx_cnt_q;
    assign tx_byte_cnt = tx_cnt_q;
    assign busy        = (state_q != StIdle);

`ifdef USB_SIWU_EN
    usb_siwu_timer #(
        .IDLE_CYCLES(SIWU_IDLE)
    ) u_siwu_timer (
        .usb_clk_60m(usb_clk_60m),
        .rst_n      (rst_n),
        .write      (wr_xfer),
        .idle       (state_q == StIdle),
        .tx_empty   (tx_empty),
        .siwu_n     (usb_siwu_n)
    );
`else
    assign usb_siwu_n = 1'b1;
`endif

endmodule
